// File: rtl/vta_axil_if.sv
// AXI-Lite bundle between the launch sequencer (master) and the VTA control
// register block (slave).
interface vta_axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/vta_launch_sequencer.sv
// Programs the VTA instruction count/address, starts it, polls the done bit
// and reads back the cycle counter; one AXI-Lite transaction at a time.
module vta_launch_sequencer #(
  parameter int CONFIG_BW_ADDR = 32,
  parameter int CONFIG_BW_DATA = 32,
  parameter int POLL_INTERVAL  = 16,
  parameter int TIMEOUT_LIMIT  = (1 << 24) - 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        launch_valid,
  output logic        launch_ready,
  input  logic [31:0] launch_insn_count,
  input  logic [31:0] launch_insn_addr,
  output logic        done_pulse,
  output logic [31:0] done_cycles,
  output logic        done_timeout,
  output logic        done_error,
  output logic        status_busy,
  vta_axil_if.master  config_sx4l
);

  typedef enum logic [3:0] {
    IDLE, WR, WRESP, POLL_WAIT, POLL_AR, POLL_R, CYC_AR, CYC_R, DONE
  } state_e;

  localparam int PCW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_INTERVAL - 1);
  localparam logic [23:0]    TMO_LAST  = 24'(TIMEOUT_LIMIT);

  localparam logic [CONFIG_BW_ADDR-1:0] REG_CTRL  = CONFIG_BW_ADDR'(32'h00);
  localparam logic [CONFIG_BW_ADDR-1:0] REG_CYC   = CONFIG_BW_ADDR'(32'h04);
  localparam logic [CONFIG_BW_ADDR-1:0] REG_COUNT = CONFIG_BW_ADDR'(32'h08);
  localparam logic [CONFIG_BW_ADDR-1:0] REG_ADDR  = CONFIG_BW_ADDR'(32'h0C);

  state_e                    state;
  logic [1:0]                wr_idx;
  logic [31:0]               insn_addr_q;
  logic [PCW-1:0]            poll_cnt;
  logic [23:0]               tmo_cnt;
  logic [23:0]               tmo_inc;
  logic                      aw_valid_q;
  logic [CONFIG_BW_ADDR-1:0] aw_addr_q;
  logic                      w_valid_q;
  logic [CONFIG_BW_DATA-1:0] w_data_q;
  logic                      b_ready_q;
  logic                      ar_valid_q;
  logic [CONFIG_BW_ADDR-1:0] ar_addr_q;
  logic                      r_ready_q;

  // Saturates so a long stall in the AR/R phases can never wrap past the limit.
  assign tmo_inc = tmo_cnt + {23'd0, ~&tmo_cnt};

  assign config_sx4l.awaddr  = aw_addr_q;
  assign config_sx4l.awvalid = aw_valid_q;
  assign config_sx4l.wdata   = w_data_q;
  assign config_sx4l.wstrb   = '1;
  assign config_sx4l.wvalid  = w_valid_q;
  assign config_sx4l.bready  = b_ready_q;
  assign config_sx4l.araddr  = ar_addr_q;
  assign config_sx4l.arvalid = ar_valid_q;
  assign config_sx4l.rready  = r_ready_q;

  // NOTE: every register here, outputs included, is assigned with <= so all
  // of them see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_idx       <= '0;
      insn_addr_q  <= '0;
      poll_cnt     <= '0;
      tmo_cnt      <= '0;
      aw_valid_q   <= 1'b0;
      aw_addr_q    <= '0;
      w_valid_q    <= 1'b0;
      w_data_q     <= '0;
      b_ready_q    <= 1'b0;
      ar_valid_q   <= 1'b0;
      ar_addr_q    <= '0;
      r_ready_q    <= 1'b0;
      launch_ready <= 1'b1;
      status_busy  <= 1'b0;
      done_pulse   <= 1'b0;
      done_cycles  <= '0;
      done_timeout <= 1'b0;
      done_error   <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (launch_valid && launch_ready) begin
            insn_addr_q  <= launch_insn_addr;
            wr_idx       <= 2'd0;
            aw_addr_q    <= REG_COUNT;
            w_data_q     <= CONFIG_BW_DATA'(launch_insn_count);
            aw_valid_q   <= 1'b1;
            w_valid_q    <= 1'b1;
            launch_ready <= 1'b0;
            status_busy  <= 1'b1;
            done_timeout <= 1'b0;
            done_error   <= 1'b0;
            state        <= WR;
          end
        end
        WR: begin
          if (aw_valid_q && config_sx4l.awready) aw_valid_q <= 1'b0;
          if (w_valid_q && config_sx4l.wready)   w_valid_q  <= 1'b0;
          if ((!aw_valid_q || config_sx4l.awready) && (!w_valid_q || config_sx4l.wready)) begin
            b_ready_q <= 1'b1;
            state     <= WRESP;
          end
        end
        WRESP: begin
          if (config_sx4l.bvalid) begin
            b_ready_q <= 1'b0;
            if (config_sx4l.bresp != 2'b00) done_error <= 1'b1;
            if (wr_idx == 2'd2) begin
              tmo_cnt  <= '0;
              poll_cnt <= '0;
              state    <= POLL_WAIT;
            end else begin
              wr_idx     <= wr_idx + 2'd1;
              aw_addr_q  <= (wr_idx == 2'd0) ? REG_ADDR : REG_CTRL;
              w_data_q   <= (wr_idx == 2'd0) ? CONFIG_BW_DATA'(insn_addr_q)
                                             : CONFIG_BW_DATA'(1);
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state      <= WR;
            end
          end
        end
        POLL_WAIT: begin
          if (tmo_cnt >= TMO_LAST) begin
            done_timeout <= 1'b1;
            done_pulse   <= 1'b1;
            state        <= DONE;
          end else begin
            tmo_cnt <= tmo_inc;
            if (poll_cnt == POLL_LAST) begin
              poll_cnt   <= '0;
              ar_addr_q  <= REG_CTRL;
              ar_valid_q <= 1'b1;
              state      <= POLL_AR;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
            end
          end
        end
        POLL_AR: begin
          tmo_cnt <= tmo_inc;
          if (config_sx4l.arready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state      <= POLL_R;
          end
        end
        POLL_R: begin
          tmo_cnt <= tmo_inc;
          if (config_sx4l.rvalid) begin
            r_ready_q <= 1'b0;
            if (config_sx4l.rresp != 2'b00) done_error <= 1'b1;
            if (config_sx4l.rdata[1]) begin
              ar_addr_q  <= REG_CYC;
              ar_valid_q <= 1'b1;
              state      <= CYC_AR;
            end else begin
              state <= POLL_WAIT;
            end
          end
        end
        CYC_AR: begin
          if (config_sx4l.arready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state      <= CYC_R;
          end
        end
        CYC_R: begin
          if (config_sx4l.rvalid) begin
            r_ready_q   <= 1'b0;
            if (config_sx4l.rresp != 2'b00) done_error <= 1'b1;
            done_cycles <= 32'(config_sx4l.rdata);
            done_pulse  <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          launch_ready <= 1'b1;
          status_busy  <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vta_launch_sequencer.sv
// Scoreboard bench: stimulus queues expected AXI writes/reads and completions,
// a monitor pops and compares them as the sequencer produces them.
module tb_vta_launch_sequencer;
  localparam int POLL = 4;
  localparam int TLIM = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        launch_valid = 1'b0;
  logic        launch_ready;
  logic [31:0] launch_insn_count = '0;
  logic [31:0] launch_insn_addr = '0;
  logic        done_pulse;
  logic [31:0] done_cycles;
  logic        done_timeout;
  logic        done_error;
  logic        status_busy;

  always #5 clk = ~clk;

  vta_axil_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  vta_launch_sequencer #(
    .CONFIG_BW_ADDR(32), .CONFIG_BW_DATA(32),
    .POLL_INTERVAL(POLL), .TIMEOUT_LIMIT(TLIM)
  ) dut (
    .clk(clk), .rst(rst),
    .launch_valid(launch_valid), .launch_ready(launch_ready),
    .launch_insn_count(launch_insn_count), .launch_insn_addr(launch_insn_addr),
    .done_pulse(done_pulse), .done_cycles(done_cycles),
    .done_timeout(done_timeout), .done_error(done_error),
    .status_busy(status_busy), .config_sx4l(axi)
  );

  typedef enum logic [1:0] {EV_W, EV_R, EV_D} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] addr;
    logic [31:0] data;
    int          aw_len;
    int          w_len;
    logic        tmo;
    logic        err;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_acc = 0;
  int  n_done = 0;

  // Slave behaviour knobs
  int          aw_delay = 0;
  int          bad_wr = -1;
  int          done_poll = 3;
  logic [31:0] cyc_val = '0;
  bit          ar_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_e k, input logic [31:0] a, input logic [31:0] d,
                      input int awl, input int wl, input logic t, input logic e);
    ev_t ev;
    ev.kind = k; ev.addr = a; ev.data = d; ev.aw_len = awl; ev.w_len = wl;
    ev.tmo = t; ev.err = e;
    sb.push_back(ev);
  endtask

  task automatic push_writes(input logic [31:0] cnt, input logic [31:0] addr, input int awl);
    push(EV_W, 32'h08, cnt,   awl, 1, 1'b0, 1'b0);
    push(EV_W, 32'h0C, addr,  awl, 1, 1'b0, 1'b0);
    push(EV_W, 32'h00, 32'h1, awl, 1, 1'b0, 1'b0);
  endtask

  task automatic push_seq(input logic [31:0] cnt, input logic [31:0] addr, input int awl,
                          input int polls, input bit cyc_rd, input logic [31:0] dcyc,
                          input logic t, input logic e);
    push_writes(cnt, addr, awl);
    for (int i = 0; i < polls; i++) push(EV_R, 32'h00, '0, 0, 0, 1'b0, 1'b0);
    if (cyc_rd) push(EV_R, 32'h04, '0, 0, 0, 1'b0, 1'b0);
    push(EV_D, '0, dcyc, 0, 0, t, e);
  endtask

  task automatic pop_ev(input ev_kind_e k, output ev_t e, output bit ok);
    ok = 1'b0;
    e = '{EV_W, '0, '0, 0, 0, 1'b0, 1'b0};
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: got unexpected %s event, expected none", k.name());
    end else begin
      e = sb.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      ok = (e.kind == k);
    end
  endtask

  // AXI-Lite slave model: samples handshakes at negedge, updates after posedge.
  initial begin : slave
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r, acc, aw_got, w_got;
    logic [31:0] ar_a;
    int aw_wait, wr_cnt, poll_n;
    aw_got = 0; w_got = 0; aw_wait = 0; wr_cnt = 0; poll_n = 0;
    axi.awready = 1'b1; axi.wready = 1'b1; axi.arready = 1'b1;
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
    forever begin
      @(negedge clk);
      hs_aw = axi.awvalid && axi.awready;
      hs_w  = axi.wvalid && axi.wready;
      hs_b  = axi.bvalid && axi.bready;
      hs_ar = axi.arvalid && axi.arready;
      hs_r  = axi.rvalid && axi.rready;
      acc   = launch_valid && launch_ready;
      ar_a  = axi.araddr;
      @(posedge clk);
      #1;
      if (rst) begin
        axi.bvalid = 1'b0; axi.rvalid = 1'b0; axi.bresp = 2'b00;
        aw_got = 0; w_got = 0; aw_wait = 0;
        axi.awready = (aw_delay == 0);
        continue;
      end
      if (acc) begin wr_cnt = 0; poll_n = 0; end
      if (hs_b) begin axi.bvalid = 1'b0; axi.bresp = 2'b00; end
      if (hs_r) axi.rvalid = 1'b0;
      if (hs_aw) aw_got = 1;
      if (hs_w)  w_got = 1;
      if (aw_got && w_got) begin
        axi.bvalid = 1'b1;
        axi.bresp  = (wr_cnt == bad_wr) ? 2'b10 : 2'b00;
        wr_cnt++;
        aw_got = 0; w_got = 0;
      end
      if (aw_delay == 0) axi.awready = 1'b1;
      else if (hs_aw) begin axi.awready = 1'b0; aw_wait = 0; end
      else if (axi.awvalid && !axi.awready) begin
        aw_wait++;
        if (aw_wait > aw_delay) axi.awready = 1'b1;
      end
      axi.arready = !ar_hold;
      if (hs_ar) begin
        axi.rvalid = 1'b1;
        axi.rresp  = 2'b00;
        if (ar_a == 32'h00) begin
          poll_n++;
          axi.rdata = (done_poll != 0 && poll_n == done_poll) ? 32'h2 : 32'h0;
        end else begin
          axi.rdata = cyc_val;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes something observable.
  initial begin : monitor
    int aw_cnt, w_cnt, aw_len, w_len, nb;
    bit aw_have, w_have, post_done, ok;
    logic [31:0] aw_a, w_d;
    logic [3:0]  w_s;
    ev_t e;
    aw_cnt = 0; w_cnt = 0; aw_len = 0; w_len = 0; nb = 0;
    aw_have = 0; w_have = 0; post_done = 0;
    aw_a = '0; w_d = '0; w_s = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_cnt = 0; w_cnt = 0; aw_have = 0; w_have = 0; post_done = 0;
        n_done = n_acc;
        continue;
      end
      if (post_done) begin
        check("done_pulse_width", 32'(done_pulse), 32'd0);
        check("ready_after_done", 32'(launch_ready), 32'd1);
        post_done = 0;
      end
      if (launch_valid && launch_ready) begin
        check("accept_only_after_done", n_acc, n_done);
        n_acc++;
        nb = 0;
      end
      if (axi.awvalid) aw_cnt++;
      if (axi.wvalid)  w_cnt++;
      if (axi.awvalid && axi.awready) begin
        aw_have = 1; aw_a = axi.awaddr; aw_len = aw_cnt; aw_cnt = 0;
      end
      if (axi.wvalid && axi.wready) begin
        w_have = 1; w_d = axi.wdata; w_s = axi.wstrb; w_len = w_cnt; w_cnt = 0;
      end
      if (aw_have && w_have) begin
        aw_have = 0; w_have = 0;
        pop_ev(EV_W, e, ok);
        if (ok) begin
          check("wr_addr", aw_a, e.addr);
          check($sformatf("wr_data@%0h", e.addr), w_d, e.data);
          check("wr_strb", 32'(w_s), 32'hF);
          check($sformatf("awvalid_cycles@%0h", e.addr), aw_len, e.aw_len);
          check($sformatf("wvalid_cycles@%0h", e.addr), w_len, e.w_len);
        end
      end
      if (axi.bvalid && axi.bready) nb++;
      if (axi.arvalid && axi.arready) begin
        pop_ev(EV_R, e, ok);
        if (ok) check("rd_addr", axi.araddr, e.addr);
      end
      if (done_pulse) begin
        pop_ev(EV_D, e, ok);
        if (ok) begin
          check("done_cycles", done_cycles, e.data);
          check("done_timeout", 32'(done_timeout), 32'(e.tmo));
          check("done_error", 32'(done_error), 32'(e.err));
        end
        check("b_per_sequence", nb, 3);
        n_done++;
        post_done = 1;
      end
    end
  end

  task automatic launch(input logic [31:0] cnt, input logic [31:0] addr);
    @(posedge clk); #1;
    launch_valid = 1'b1; launch_insn_count = cnt; launch_insn_addr = addr;
    @(posedge clk); #1;
    launch_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < 2000 && n_done < target; i++) @(negedge clk);
    if (n_done < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %0d completions before cycle limit, expected %0d", name, n_done, target);
    end
    @(negedge clk);
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin : stim
    int base;
    bit seen;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_launch_ready", 32'(launch_ready), 32'd1);
    check("rst_busy",         32'(status_busy),  32'd0);
    check("rst_done_pulse",   32'(done_pulse),   32'd0);
    check("rst_done_cycles",  done_cycles,       32'd0);
    check("rst_timeout",      32'(done_timeout), 32'd0);
    check("rst_error",        32'(done_error),   32'd0);
    check("rst_valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 32'd0);

    // Nominal launch, done on the third poll
    done_poll = 3; cyc_val = 32'h1234;
    push_seq(32'd5, 32'h8000_0000, 1, 3, 1'b1, 32'h1234, 1'b0, 1'b0);
    launch(32'd5, 32'h8000_0000);
    @(negedge clk);
    check("busy_during_seq", 32'(status_busy), 32'd1);
    wait_done(1, "nominal");

    // Slow awready, immediate wready
    aw_delay = 3; axi.awready = 1'b0; done_poll = 1; cyc_val = 32'h55;
    push_seq(32'd7, 32'h0000_1000, 4, 1, 1'b1, 32'h55, 1'b0, 1'b0);
    launch(32'd7, 32'h0000_1000);
    wait_done(2, "aw_delay");
    aw_delay = 0; axi.awready = 1'b1;

    // Done never set: 17 polls fit before the limit, done_cycles unchanged
    done_poll = 0;
    push_seq(32'd1, 32'h0000_2000, 1, 17, 1'b0, 32'h55, 1'b1, 1'b0);
    launch(32'd1, 32'h0000_2000);
    wait_done(3, "timeout");

    // Error response on the second write, then cleared by the next launch
    bad_wr = 1; done_poll = 1; cyc_val = 32'h99;
    push_seq(32'd2, 32'h0000_3000, 1, 1, 1'b1, 32'h99, 1'b0, 1'b1);
    launch(32'd2, 32'h0000_3000);
    wait_done(4, "bresp_err");
    bad_wr = -1; done_poll = 2; cyc_val = 32'hABC;
    push_seq(32'd3, 32'h0000_4000, 1, 2, 1'b1, 32'hABC, 1'b0, 1'b0);
    launch(32'd3, 32'h0000_4000);
    wait_done(5, "err_cleared");

    // launch_valid held across a whole sequence: exactly two accepted
    done_poll = 1; cyc_val = 32'h31;
    base = n_acc;
    push_seq(32'd9, 32'h40, 1, 1, 1'b1, 32'h31, 1'b0, 1'b0);
    push_seq(32'd9, 32'h40, 1, 1, 1'b1, 32'h31, 1'b0, 1'b0);
    @(posedge clk); #1;
    launch_valid = 1'b1; launch_insn_count = 32'd9; launch_insn_addr = 32'h40;
    for (int i = 0; i < 1000 && n_acc < base + 2; i++) @(negedge clk);
    check("held_valid_accepts", n_acc - base, 2);
    @(posedge clk); #1;
    launch_valid = 1'b0;
    wait_done(base + 2, "held_valid");

    // Reset while an AR is outstanding
    ar_hold = 1'b1; axi.arready = 1'b0;
    push_writes(32'd4, 32'h100, 1);
    launch(32'd4, 32'h100);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = axi.arvalid;
    end
    check("arvalid_before_rst", 32'(seen), 32'd1);
    check("sb_empty_before_rst", sb.size(), 0);
    #2 rst = 1'b1;
    #1;
    check("rst_arvalid", 32'(axi.arvalid), 32'd0);
    check("rst_busy_mid", 32'(status_busy), 32'd0);
    check("rst_readies", 32'({axi.bready, axi.rready}), 32'd0);
    check("rst_cycles_mid", done_cycles, 32'd0);
    sb.delete();
    ar_hold = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    done_poll = 1; cyc_val = 32'h77;
    base = n_done;
    push_seq(32'd3, 32'h200, 1, 1, 1'b1, 32'h77, 1'b0, 1'b0);
    launch(32'd3, 32'h200);
    wait_done(base + 1, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vta_launch_sequencer.md
VTA_LAUNCH_SEQUENCER -- requirements
Module: vta_launch_sequencer

Interface
REQ-001 SHALL have parameter CONFIG_BW_ADDR, default 32, config AXI-Lite address width.
REQ-002 SHALL have parameter CONFIG_BW_DATA, default 32, config AXI-Lite data width.
REQ-003 SHALL have parameter POLL_INTERVAL, default 16, idle cycles between done-register polls (>=1).
REQ-004 SHALL have parameter TIMEOUT_LIMIT, default 2^24-1, max cycles from start-write B to done.
REQ-005 SHALL have ports: clk input 1 (single clock); rst input 1 (reset, asynchronous, active-high).
REQ-006 SHALL have ports: launch_valid in 1; launch_ready out 1; launch_insn_count in 32; launch_insn_addr in 32 (launch request).
REQ-007 SHALL have ports: done_pulse out 1; done_cycles out 32; done_timeout out 1; done_error out 1; status_busy out 1.
REQ-008 SHALL have AXI-Lite master ports config_sx4lawaddr/awvalid/awready, config_sx4lwdata/wstrb(CONFIG_BW_DATA/8)/wvalid/wready, config_sx4lbresp(2)/bvalid/bready, config_sx4laraddr/arvalid/arready, config_sx4lrdata/rresp(2)/rvalid/rready.

Function
REQ-009 SHALL accept a launch when launch_valid&&launch_ready; launch_ready SHALL be 1 only in IDLE; count and address SHALL be captured on acceptance.
REQ-010 SHALL use states IDLE, WR, WRESP, POLL_WAIT, POLL_AR, POLL_R, CYC_AR, CYC_R, DONE.
REQ-011 SHALL perform three writes in order via a 2-bit index: 0x08<-insn_count, 0x0C<-insn_addr, 0x00<-0x1 (start); wstrb SHALL be all ones.
REQ-012 In WR, SHALL assert awvalid and wvalid in the same cycle, drop each independently on its own ready, hold the other until its ready, and enter WRESP when both have completed (same-cycle completion allowed).
REQ-013 In WRESP, bready SHALL be 1; on bvalid go to WR with index+1, or to POLL_WAIT after the start write.
REQ-014 AW/W/AR address and data SHALL remain stable while the corresponding valid is high.
REQ-015 POLL_WAIT SHALL count POLL_INTERVAL cycles, then enter POLL_AR with araddr=0x00; on arready enter POLL_R with rready=1.
REQ-016 On rvalid in POLL_R: rdata[1]=1 -> CYC_AR; else -> POLL_WAIT.
REQ-017 CYC_AR SHALL read 0x04; on rvalid in CYC_R, done_cycles SHALL latch rdata and the FSM enters DONE.
REQ-018 A 24-bit timeout counter SHALL clear on start-write B, increment each cycle through POLL states, and on reaching TIMEOUT_LIMIT (checked in POLL_WAIT only, no outstanding transaction) set done_timeout and enter DONE, skipping CYC reads.
REQ-019 Any bresp or rresp != 0 SHALL set sticky done_error; the sequence SHALL continue.
REQ-020 DONE SHALL assert done_pulse for exactly one cycle, then return to IDLE; done_cycles/timeout/error SHALL hold until the next launch acceptance, which clears timeout and error.
REQ-021 status_busy SHALL be 1 in every state except IDLE.
REQ-022 bready SHALL be 1 only in WRESP; rready only in POLL_R/CYC_R; no more than one outstanding transaction at any time.
REQ-023 launch_valid while busy SHALL be ignored (not queued).

Reset
REQ-024 On rst assertion, regardless of state, SHALL go to IDLE immediately; all valids, bready, rready, done_pulse, done_timeout, done_error, status_busy = 0; done_cycles = 0; counters = 0; launch_ready = 1 once rst is low.
REQ-025 Reset mid-transaction SHALL abandon it without completing handshakes.

Verification
REQ-026 Launch count=5, addr=0x8000_0000, zero-wait slave, done set on 3rd poll, cycles reg=0x1234 -> writes 0x08=5, 0x0C=0x8000_0000, 0x00=1 in order; three reads of 0x00; one read of 0x04; done_pulse 1 cycle; done_cycles=0x1234; timeout=0, error=0.
REQ-027 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, single B per write, no duplicate writes.
REQ-028 TIMEOUT_LIMIT=100, done never set -> done_pulse with done_timeout=1, no 0x04 read, launch_ready=1 next cycle.
REQ-029 bresp=2 on 2nd write -> sequence completes, done_error=1; next launch clears it to 0.
REQ-030 rst asserted with arvalid=1 in POLL_AR -> arvalid=0 and status_busy=0 within the reset cycle; new launch after rst low starts again at 0x08 write.
REQ-031 launch_valid held high during busy -> exactly one sequence per accepted launch; second accepted only after done_pulse.
